// File: rtl/bank_group_rr_arbiter.sv
// Round-robin grant of the shared command/data path to one of NUM_GROUPS bank-group queues.
// A grant is held until the group drops its request, hits its burst limit, or times out.
module bank_group_rr_arbiter #(
   parameter int NUM_GROUPS   = 4,
   parameter int MAX_BURSTS   = 4,
   parameter int BURST_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [$clog2(MAX_BURSTS):0]   num_bursts,
   input  logic [NUM_GROUPS-1:0]         req,
   input  logic                          burst_done,
   output logic [NUM_GROUPS-1:0]         grant,
   output logic                          grant_valid,
   output logic [$clog2(NUM_GROUPS)-1:0] grant_idx,
   output logic                          timeout
);

   localparam int NB_W  = $clog2(MAX_BURSTS) + 1;
   localparam int IDX_W = $clog2(NUM_GROUPS);
   localparam int T_W   = $clog2(MAX_BURSTS * BURST_CYCLES + 1);

   localparam logic [NB_W-1:0]  NB_ONE = NB_W'(1);
   localparam logic [NB_W-1:0]  NB_MAX = NB_W'(MAX_BURSTS);
   localparam logic [T_W-1:0]   T_ONE  = T_W'(1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_GROUPS - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                r_state,       w_state_nxt;
   logic [NUM_GROUPS-1:0] r_grant,       w_grant_nxt;
   logic                  r_grant_valid, w_grant_valid_nxt;
   logic [IDX_W-1:0]      r_grant_idx,   w_grant_idx_nxt;
   logic                  r_timeout,     w_timeout_nxt;
   logic [IDX_W-1:0]      r_last,        w_last_nxt;
   logic [NB_W-1:0]       r_limit,       w_limit_nxt;
   logic [NB_W-1:0]       r_burst_cnt,   w_burst_cnt_nxt;
   logic [T_W-1:0]        r_timer,       w_timer_nxt;

   logic [NB_W-1:0]  w_limit_in;
   logic [T_W-1:0]   w_thresh;
   logic [IDX_W-1:0] w_base;
   logic [IDX_W-1:0] w_cand;
   logic [IDX_W-1:0] w_pick;
   logic             w_found;
   logic             w_r1, w_r2, w_r3, w_release;

   always_comb begin
      if (num_bursts == '0) begin
         w_limit_in = NB_ONE;
      end else if (num_bursts > NB_MAX) begin
         w_limit_in = NB_MAX;
      end else begin
         w_limit_in = num_bursts;
      end
   end

   assign w_thresh = T_W'(r_limit) * T_W'(BURST_CYCLES);

   // Searching offsets N..1 downward so the smallest offset wins; offset N is the base
   // itself, which gives the re-grant of the current group when nobody else asks.
   assign w_base = (r_state == GRANT) ? r_grant_idx : r_last;

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = NUM_GROUPS; k >= 1; k--) begin
         w_cand = IDX_W'((int'(w_base) + k) % NUM_GROUPS);
         if (req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   assign w_r1      = ~req[r_grant_idx];
   assign w_r2      = burst_done && ((r_burst_cnt + NB_ONE) >= r_limit);
   assign w_r3      = (r_timer == (w_thresh - T_ONE)) && !w_r2;
   assign w_release = w_r1 || w_r2 || w_r3;

   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_grant_valid_nxt = r_grant_valid;
      w_grant_idx_nxt   = r_grant_idx;
      w_timeout_nxt     = 1'b0;
      w_last_nxt        = r_last;
      w_limit_nxt       = r_limit;
      w_burst_cnt_nxt   = r_burst_cnt;
      w_timer_nxt       = r_timer;

      if ((r_state == GRANT) && w_release) begin
         w_last_nxt    = r_grant_idx;
         w_timeout_nxt = w_r3 && !w_r1;
      end else if (r_state == GRANT) begin
         if (r_timer != w_thresh) begin
            w_timer_nxt = r_timer + T_ONE;
         end
         if (burst_done) begin
            w_burst_cnt_nxt = r_burst_cnt + NB_ONE;
         end
      end

      if ((r_state == IDLE) || w_release) begin
         if (en && w_found) begin
            w_state_nxt         = GRANT;
            w_grant_nxt         = '0;
            w_grant_nxt[w_pick] = 1'b1;
            w_grant_valid_nxt   = 1'b1;
            w_grant_idx_nxt     = w_pick;
            w_limit_nxt         = w_limit_in;
            w_burst_cnt_nxt     = '0;
            w_timer_nxt         = '0;
         end else begin
            w_state_nxt       = IDLE;
            w_grant_nxt       = '0;
            w_grant_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_grant_valid <= 1'b0;
         r_grant_idx   <= '0;
         r_timeout     <= 1'b0;
         r_last        <= LAST_RST;
         r_limit       <= NB_ONE;
         r_burst_cnt   <= '0;
         r_timer       <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_valid <= w_grant_valid_nxt;
         r_grant_idx   <= w_grant_idx_nxt;
         r_timeout     <= w_timeout_nxt;
         r_last        <= w_last_nxt;
         r_limit       <= w_limit_nxt;
         r_burst_cnt   <= w_burst_cnt_nxt;
         r_timer       <= w_timer_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_grant_valid;
   assign grant_idx   = r_grant_idx;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_bank_group_rr_arbiter.sv
// Bench for bank_group_rr_arbiter: directed scenarios then random traffic, every cycle
// compared against a grant-level reference model.
module tb_bank_group_rr_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int BC = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [2:0] num_bursts = 3'd1;
   logic [3:0] req = 4'b0000;
   logic       burst_done = 1'b0;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_idx;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   // Model: which group holds the grant (-1 = none) and how long / how many bursts.
   int m_cur  = -1;
   int m_last = N - 1;
   int m_idx  = 0;
   int m_lim  = 1;
   int m_bursts = 0;
   int m_age  = 0;
   int m_to   = 0;

   bank_group_rr_arbiter #(.NUM_GROUPS(N), .MAX_BURSTS(MB), .BURST_CYCLES(BC)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .num_bursts(num_bursts), .req(req),
      .burst_done(burst_done), .grant(grant), .grant_valid(grant_valid),
      .grant_idx(grant_idx), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_from(input int base);
      for (int k = 1; k <= N; k++) begin
         if (req[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   task automatic m_start(input int g);
      m_cur    = g;
      m_idx    = g;
      m_lim    = (num_bursts == 0) ? 1 : ((int'(num_bursts) > MB) ? MB : int'(num_bursts));
      m_bursts = 0;
      m_age    = 0;
   endtask

   task automatic model_step();
      int  p;
      bit  rel;
      if (!rst_n) begin
         m_cur = -1; m_last = N - 1; m_idx = 0; m_to = 0;
         return;
      end
      m_to = 0;
      if (m_cur < 0) begin
         p = find_from(m_last);
         if (en && p >= 0) m_start(p);
      end else begin
         rel = 0;
         if (!req[m_cur]) rel = 1;
         else if (burst_done && m_bursts + 1 >= m_lim) rel = 1;
         else if (m_age == m_lim * BC - 1) begin rel = 1; m_to = 1; end
         if (rel) begin
            m_last = m_cur;
            p = find_from(m_cur);
            if (en && p >= 0) m_start(p);
            else m_cur = -1;
         end else begin
            m_age++;
            if (burst_done) m_bursts++;
         end
      end
   endtask

   task automatic tick();
      logic [3:0] eg;
      model_step();
      @(posedge clk);
      #1;
      eg = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
      chk("grant", grant, eg);
      chk("grant_valid", grant_valid, (m_cur >= 0));
      chk("grant_idx", grant_idx, m_idx);
      chk("timeout", timeout, m_to);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; burst_done = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic pulse();
      burst_done = 1'b1; tick(); burst_done = 1'b0;
   endtask

   initial begin
      int n;
      bit dropped;

      // Reset values
      do_reset();
      chk("rst_grant", grant, 4'b0000);
      chk("rst_valid", grant_valid, 1'b0);
      chk("rst_idx", grant_idx, 2'd0);
      chk("rst_timeout", timeout, 1'b0);

      // Two groups, burst limit 2: hand-over with no bubble and no timeout
      en = 1'b1; num_bursts = 3'd2; req = 4'b0101;
      tick();
      chk("s1_first", grant, 4'b0001);
      pulse(); tick(); pulse();
      chk("s1_handover", grant, 4'b0100);
      chk("s1_no_to", timeout, 1'b0);

      // All requesting, one burst per grant
      do_reset();
      req = 4'b1111; num_bursts = 3'd1;
      for (int i = 0; i < 14; i++) begin
         burst_done = (i % 3 == 2);
         tick();
      end
      burst_done = 1'b0;

      // Lone requester times out after 2*16 cycles and is re-granted without a gap
      do_reset();
      req = 4'b0010; num_bursts = 3'd2;
      tick();
      chk("s3_grant", grant, 4'b0010);
      n = 0; dropped = 0;
      do begin
         tick(); n++;
         if (!grant_valid) dropped = 1;
      end while (!timeout && n < 200);
      chk("s3_to_cycles", n, 32);
      chk("s3_regrant", grant, 4'b0010);
      chk("s3_no_drop", dropped, 1'b0);

      // Request drop: search resumes after the released group
      do_reset();
      req = 4'b0100;
      tick();
      chk("s4_g2", grant, 4'b0100);
      req = 4'b1001;
      tick();
      chk("s4_g3", grant, 4'b1000);
      req = 4'b0001;
      tick();
      chk("s4_g0", grant, 4'b0001);

      // num_bursts=0 acts as 1
      do_reset();
      req = 4'b0011; num_bursts = 3'd0;
      tick();
      pulse();
      chk("s5_nb0", grant, 4'b0010);

      // num_bursts=7 clamps to 4 bursts and a 64-cycle timeout
      do_reset();
      num_bursts = 3'd7;
      tick();
      pulse(); tick(); pulse(); tick(); pulse(); tick();
      chk("s5_hold3", grant, 4'b0001);
      pulse();
      chk("s5_rel4", grant, 4'b0010);
      n = 0;
      do begin tick(); n++; end while (!timeout && n < 200);
      chk("s5_to_cycles", n, 64);

      // Enable dropped mid-grant: grant finishes then arbiter idles
      do_reset();
      req = 4'b1111; num_bursts = 3'd2;
      tick();
      en = 1'b0;
      pulse(); tick(); pulse();
      chk("s6_idle", grant, 4'b0000);
      for (int i = 0; i < 5; i++) tick();
      chk("s6_stay_idle", grant_valid, 1'b0);
      en = 1'b1;
      tick();
      chk("s6_resume", grant, 4'b0010);
      rst_n = 1'b0;
      tick();
      chk("s6_reset_mid", grant, 4'b0000);
      rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(199) != 0);
         en         = ($urandom_range(9) != 0);
         num_bursts = 3'($urandom_range(7));
         if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
         burst_done = ($urandom_range(9) < 3);
         tick();
         chk("onehot", $onehot0(grant), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
